pwm_int_core: RTL and testbench
===============================

Name: pwm_int_core

Overview:
- PWM generation core with period interrupt; sits directly downstream of the 4-register AXI4-Lite slave of the PWM_Int_4 peripheral.
- Register values arrive from the slave as static levels; this block produces the PWM waveform, period-end interrupt and status.
- Register map it serves: reg0 = ctrl, reg1 = period, reg2 = duty, reg3 = prescale. A write-1 to reg0 bit 8 is delivered here as the irq_clr pulse.

Parameters:
CNT_W, 32, width of period/duty/counter
PRESC_W, 16, width of prescaler divider
WRAP_W, 16, width of completed-period counter

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
ctrl_enable  in  1  run enable (reg0 bit0)
ctrl_irq_en  in  1  interrupt enable (reg0 bit1)
ctrl_polarity  in  1  1 = active-low output (reg0 bit2)
cfg_prescale  in  PRESC_W  tick every cfg_prescale+1 clocks
cfg_period  in  CNT_W  period in ticks
cfg_duty  in  CNT_W  high ticks per period
irq_clr  in  1  single-cycle pulse, clears pending interrupt
pwm_out  out  1  registered PWM output
irq  out  1  level interrupt = pending & ctrl_irq_en
period_done  out  1  one-cycle pulse at each period wrap
cnt_value  out  CNT_W  current counter value
wrap_count  out  WRAP_W  completed periods, modulo 2^WRAP_W
cfg_err  out  1  high while enabled with shadow period == 0

Behaviour:
- Reset (async, ARESET=1): all state 0. pwm_out=0, irq=0, period_done=0, cnt_value=0, wrap_count=0, cfg_err=0, all shadows 0. Release is synchronous to ACLK.
- States: IDLE (enable=0) and RUN.
  - IDLE->RUN on the first cycle ctrl_enable=1. In that cycle sh_period, sh_duty, sh_presc and sh_pol are loaded from the inputs, and cnt and presc_cnt are set to 0.
  - RUN->IDLE on the first cycle ctrl_enable=0. Next edge: cnt=0, presc_cnt=0. pending and wrap_count are retained.
- Prescaler:
  - In RUN, presc_cnt increments each clock.
  - tick = (presc_cnt == sh_presc); on tick, presc_cnt wraps to 0.
  - sh_presc=0 gives a tick every clock.
- Counter:
  - On tick, cnt increments.
  - If cnt == sh_period-1 at the tick, this is terminal count (tc): cnt wraps to 0.
  - Compare is full CNT_W unsigned; no overflow is possible since cnt < sh_period.
- Shadow update:
  - On tc, all four shadows reload from the current inputs.
  - Input changes mid-period never take effect before the period boundary. This makes the update glitch-free.
- Output:
  - raw = (cnt < sh_duty), unsigned.
  - duty=0 gives a constant inactive level. duty >= period gives a constant active level.
  - pwm_out is registered: value = raw ^ sh_pol in RUN, sh_pol in IDLE. One clock latency from cnt to pwm_out.
- period_zero guard:
  - If sh_period==0 in RUN: cfg_err=1, cnt held at 0, pwm_out = inactive level, no tc, no irq.
  - Shadows still reload each cycle while sh_period==0 so a later nonzero period is picked up; cfg_err clears the cycle after.
- Interrupt:
  - On tc: pending<=1, period_done pulses 1 cycle (registered, same edge cnt wraps), wrap_count += 1 (wraps modulo).
  - irq_clr clears pending. If tc and irq_clr coincide, set wins and pending stays 1.
  - irq = pending & ctrl_irq_en, registered. Toggling irq_en masks the output without losing pending.
- Enable drop coinciding with tc: tc takes effect (pending set, wrap_count incremented), then IDLE.
- cnt_value reflects the cnt register directly.

Test Plan:
- Reset: hold ARESET mid-RUN -> all outputs 0 within the same cycle (async); after release, IDLE with pwm_out=0.
- Basic PWM: presc=0, period=4, duty=1, pol=0, enable -> pwm_out pattern 1,0,0,0 repeating starting 1 clock after enable; period_done every 4 clocks; wrap_count=3 after 12 clocks of RUN.
- Prescale + polarity: presc=2, period=2, duty=1, pol=1 -> pwm_out low 3 clocks, high 3 clocks; tick every 3 clocks.
- Shadow timing: period=8, duty=2; write duty=6 at cnt=3 -> current period stays high 2 ticks; next period high 6 ticks.
- Edge duty: duty=0 -> constant 0. duty=9 with period=8 -> constant 1. Both cases: period_done still every 8 ticks.
- Interrupt: irq_en=1, period=4 -> irq rises 1 clock after first tc. irq_clr coincident with next tc -> irq stays 1. irq_clr alone -> irq=0 next clock. irq_en=0 with pending=1 -> irq=0; set irq_en=1 -> irq=1.
- Zero period: enable with period=0 -> cfg_err=1, pwm_out=0, no period_done. Set period=4 -> cfg_err=0 next cycle and normal operation.

Source files
------------

// File: rtl/pwm_int_core.sv
// Purpose: PWM waveform generator with prescaler, shadowed period/duty/prescale/polarity,
//          period-end interrupt, period-wrap counter and zero-period configuration error.
// Latency: pwm_out, period_done, irq and cfg_err are registered; pwm_out lags cnt by one clock.
// Backpressure: none; the core free-runs from static register levels and never stalls.
//
// Ports:
//   ACLK, ARESET               clock, asynchronous active-high reset
//   ctrl_enable/irq_en/polarity  reg0 control bits (static levels)
//   cfg_prescale/period/duty   reg3/reg1/reg2 configuration (static levels)
//   irq_clr                    one-cycle pulse from a write-1 to reg0 bit 8
//   pwm_out, irq, period_done  waveform, level interrupt, per-wrap pulse
//   cnt_value, wrap_count      live counter and completed-period count
//   cfg_err                    running with a zero shadow period
module pwm_int_core #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16,
  parameter int WRAP_W  = 16
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               ctrl_enable,
  input  logic               ctrl_irq_en,
  input  logic               ctrl_polarity,
  input  logic [PRESC_W-1:0] cfg_prescale,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_duty,
  input  logic               irq_clr,
  output logic               pwm_out,
  output logic               irq,
  output logic               period_done,
  output logic [CNT_W-1:0]   cnt_value,
  output logic [WRAP_W-1:0]  wrap_count,
  output logic               cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;

  logic [CNT_W-1:0]   sh_period, sh_duty;
  logic [PRESC_W-1:0] sh_presc;
  logic               sh_pol;

  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PRESC_W-1:0] presc_cnt, presc_nxt;
  logic               pending, pending_nxt;

  logic               load;     // reload all four shadows from the inputs
  logic               tick;
  logic               tc;       // terminal count: last tick of a period
  logic               pwm_nxt;
  logic               err_nxt;
  logic               period_zero;

  assign period_zero = (sh_period == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    presc_nxt = presc_cnt;
    load      = 1'b0;
    tick      = 1'b0;
    tc        = 1'b0;
    pwm_nxt   = sh_pol;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl_enable) begin
          state_nxt = RUN;
          load      = 1'b1;
          cnt_nxt   = '0;
          presc_nxt = '0;
        end
      end
      RUN: begin
        if (period_zero) begin
          // Keep sampling the inputs so a later nonzero period starts a clean period.
          load      = 1'b1;
          cnt_nxt   = '0;
          presc_nxt = '0;
          err_nxt   = ctrl_enable;
        end else begin
          pwm_nxt = (cnt < sh_duty) ^ sh_pol;
          tick    = (presc_cnt == sh_presc);
          if (tick) begin
            presc_nxt = '0;
            if (cnt == sh_period - CNT_W'(1)) begin
              tc      = 1'b1;
              cnt_nxt = '0;
              load    = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            presc_nxt = presc_cnt + PRESC_W'(1);
          end
        end
        // A terminal count in the same cycle still counts; only the counters clear.
        if (!ctrl_enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          presc_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Set beats clear when tc and irq_clr coincide.
    pending_nxt = tc | (pending & ~irq_clr);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= IDLE;
      sh_period   <= '0;
      sh_duty     <= '0;
      sh_presc    <= '0;
      sh_pol      <= 1'b0;
      cnt         <= '0;
      presc_cnt   <= '0;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      irq         <= 1'b0;
      period_done <= 1'b0;
      wrap_count  <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      presc_cnt   <= presc_nxt;
      pending     <= pending_nxt;
      pwm_out     <= pwm_nxt;
      irq         <= pending_nxt & ctrl_irq_en;
      period_done <= tc;
      cfg_err     <= err_nxt;
      if (tc) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
      if (load) begin
        sh_period <= cfg_period;
        sh_duty   <= cfg_duty;
        sh_presc  <= cfg_prescale;
        sh_pol    <= ctrl_polarity;
      end
    end
  end

  assign cnt_value = cnt;

endmodule

// File: tb/tb_pwm_int_core.sv
// Purpose: self-checking bench for pwm_int_core: directed scenarios plus randomized traffic
//          checked every clock against a reference model that tracks clocks-into-period.
// Latency: outputs sampled 1 time unit after each rising ACLK edge.
// Backpressure: not applicable.
module tb_pwm_int_core;

  localparam int CNT_W   = 32;
  localparam int PRESC_W = 16;
  localparam int WRAP_W  = 16;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               ctrl_enable, ctrl_irq_en, ctrl_polarity, irq_clr;
  logic [PRESC_W-1:0] cfg_prescale;
  logic [CNT_W-1:0]   cfg_period, cfg_duty;
  logic               pwm_out, irq, period_done, cfg_err;
  logic [CNT_W-1:0]   cnt_value;
  logic [WRAP_W-1:0]  wrap_count;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_int_core #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .WRAP_W(WRAP_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ctrl_enable(ctrl_enable), .ctrl_irq_en(ctrl_irq_en), .ctrl_polarity(ctrl_polarity),
    .cfg_prescale(cfg_prescale), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .irq_clr(irq_clr),
    .pwm_out(pwm_out), .irq(irq), .period_done(period_done),
    .cnt_value(cnt_value), .wrap_count(wrap_count), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: a period is (period * (prescale+1)) clocks long; the counter value
  // is simply clocks-into-period divided by the prescale ratio.
  bit              m_run, m_pol, m_pend, m_pwm, m_irq, m_pd, m_err;
  longint unsigned m_q, m_per, m_duty, m_presc;
  logic [WRAP_W-1:0] m_wrap;

  task automatic model_reset();
    m_run = 0; m_pol = 0; m_pend = 0; m_pwm = 0; m_irq = 0; m_pd = 0; m_err = 0;
    m_q = 0; m_per = 0; m_duty = 0; m_presc = 0; m_wrap = '0;
  endtask

  task automatic model_load();
    m_per = cfg_period; m_duty = cfg_duty; m_presc = cfg_prescale; m_pol = ctrl_polarity;
  endtask

  task automatic model_step();
    bit tc;
    longint unsigned ratio;
    tc = 0;
    if (!m_run) begin
      m_pwm = m_pol; m_pd = 0; m_err = 0;
      if (ctrl_enable) begin m_run = 1; model_load(); m_q = 0; end
    end else begin
      ratio = m_presc + 1;
      if (m_per == 0) begin
        m_pwm = m_pol; m_err = ctrl_enable; model_load(); m_q = 0;
      end else begin
        m_err = 0;
        m_pwm = ((m_q / ratio) < m_duty) ^ m_pol;
        if (m_q == m_per * ratio - 1) begin tc = 1; m_q = 0; model_load(); end
        else m_q = m_q + 1;
      end
      m_pd = tc;
      if (tc) m_wrap = m_wrap + 1'b1;
      if (!ctrl_enable) begin m_run = 0; m_q = 0; end
    end
    m_pend = tc ? 1'b1 : (irq_clr ? 1'b0 : m_pend);
    m_irq  = m_pend & ctrl_irq_en;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint unsigned exp_cnt;
    exp_cnt = m_run ? m_q / (m_presc + 1) : 0;
    chk("pwm_out", pwm_out, m_pwm);
    chk("irq", irq, m_irq);
    chk("period_done", period_done, m_pd);
    chk("cnt_value", cnt_value, exp_cnt);
    chk("wrap_count", wrap_count, m_wrap);
    chk("cfg_err", cfg_err, m_err);
  endtask

  // One clock: predict, clock, then compare away from the edge.
  task automatic cyc();
    model_step();
    @(posedge ACLK);
    #1;
    check_all();
  endtask

  // Return to IDLE with pending cleared.
  task automatic idle_init();
    ctrl_enable = 0; irq_clr = 1; cyc();
    irq_clr = 0; cyc(); cyc();
  endtask

  task automatic setup(input int presc, input int per, input int duty, input bit pol);
    cfg_prescale = PRESC_W'(presc); cfg_period = CNT_W'(per);
    cfg_duty = CNT_W'(duty); ctrl_polarity = pol;
  endtask

  initial begin
    int hi1, hi2, pds;
    logic [WRAP_W-1:0] w0, wdelta;

    ARESET = 1; ctrl_enable = 0; ctrl_irq_en = 0; ctrl_polarity = 0; irq_clr = 0;
    cfg_prescale = '0; cfg_period = '0; cfg_duty = '0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 0;
    #1 check_all();

    // Basic PWM: 1,0,0,0 repeating, period_done every 4 clocks.
    setup(0, 4, 1, 0);
    idle_init();
    w0 = wrap_count;
    ctrl_enable = 1; cyc();
    pds = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("basic_pwm", pwm_out, ((k - 1) % 4) == 0);
      pds += int'(period_done);
    end
    wdelta = wrap_count - w0;
    chk("basic_wraps", wdelta, 3);
    chk("basic_pd_count", pds, 3);

    // Prescale + polarity: low 3 clocks, high 3 clocks.
    idle_init();
    setup(2, 2, 1, 1);
    ctrl_enable = 1; cyc();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("presc_pol_pwm", pwm_out, (((k - 1) / 3) % 2) == 1);
    end

    // Shadow timing: duty change mid-period applies only from the next period.
    idle_init();
    setup(0, 8, 2, 0);
    ctrl_enable = 1; cyc();
    hi1 = 0; hi2 = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k <= 8) hi1 += int'(pwm_out); else hi2 += int'(pwm_out);
      if (k == 3) cfg_duty = 6;
    end
    chk("shadow_p1_high", hi1, 2);
    chk("shadow_p2_high", hi2, 6);

    // Edge duties: 0 -> never active, >= period -> always active.
    for (int d = 0; d < 2; d++) begin
      idle_init();
      setup(0, 8, (d == 0) ? 0 : 9, 0);
      ctrl_enable = 1; cyc();
      hi1 = 0; pds = 0;
      for (int k = 1; k <= 16; k++) begin
        cyc();
        hi1 += int'(pwm_out); pds += int'(period_done);
      end
      chk("edge_duty_high", hi1, (d == 0) ? 0 : 16);
      chk("edge_duty_pd", pds, 2);
    end

    // Interrupt set/clear/mask behaviour.
    idle_init();
    setup(0, 4, 1, 0);
    ctrl_irq_en = 1;
    ctrl_enable = 1; cyc();
    for (int k = 1; k <= 3; k++) cyc();
    chk("irq_before_tc", irq, 0);
    cyc(); chk("irq_first_tc", irq, 1);
    repeat (3) cyc();
    irq_clr = 1; cyc(); irq_clr = 0;
    chk("irq_clr_with_tc", irq, 1);
    cyc();
    irq_clr = 1; cyc(); irq_clr = 0;
    chk("irq_clr_alone", irq, 0);
    cyc(); cyc();
    chk("irq_third_tc", irq, 1);
    ctrl_irq_en = 0; cyc(); chk("irq_masked", irq, 0);
    ctrl_irq_en = 1; cyc(); chk("irq_unmasked", irq, 1);

    // Zero period guard and recovery.
    idle_init();
    setup(0, 0, 2, 0);
    ctrl_enable = 1; cyc();
    pds = 0; hi1 = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      pds += int'(period_done); hi1 += int'(pwm_out);
    end
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_pwm", hi1, 0);
    chk("zero_pd", pds, 0);
    cfg_period = 4;
    cyc(); chk("zero_err_hold", cfg_err, 1);
    cyc(); chk("zero_err_clear", cfg_err, 0);
    pds = int'(period_done);
    for (int k = 6; k <= 12; k++) begin cyc(); pds += int'(period_done); end
    chk("zero_recover_pd", pds, 2);

    // Randomized traffic against the model.
    ctrl_irq_en = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ctrl_enable = ~ctrl_enable;
      if ($urandom_range(0, 29) == 0) cfg_period = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) cfg_duty = CNT_W'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) cfg_prescale = PRESC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) ctrl_polarity = ~ctrl_polarity;
      if ($urandom_range(0, 49) == 0) ctrl_irq_en = ~ctrl_irq_en;
      irq_clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    irq_clr = 0;

    // Asynchronous reset mid-run clears outputs without a clock edge.
    setup(0, 4, 2, 0);
    ctrl_enable = 1; ctrl_irq_en = 1;
    repeat (10) cyc();
    ARESET = 1;
    #1;
    model_reset();
    check_all();
    @(posedge ACLK);
    #1 ARESET = 0;
    ctrl_enable = 0;
    #1 check_all();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
